// File: rtl/counter_maximum_cmp.sv
// WIDTH-bit equality comparator used for the wrap flag.
// IMPLEMENTATION selects a plain == or a balanced XNOR-reduction tree.
module counter_maximum_cmp #(
  parameter int WIDTH          = 4,
  parameter int IMPLEMENTATION = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq
);

  generate
    if (IMPLEMENTATION == 1) begin : g_xnor_tree
      logic [WIDTH-1:0] bit_eq;
      logic [WIDTH-1:0] tree;

      assign bit_eq = a ~^ b;

      // Pairwise AND at doubling strides; the final result collects in tree[0].
      always_comb begin
        tree = bit_eq;
        for (int unsigned s = 1; s < WIDTH; s = s * 2) begin
          for (int unsigned i = 0; i + s < WIDTH; i = i + 2 * s) begin
            tree[i] = tree[i] & tree[i+s];
          end
        end
        eq = tree[0];
      end
    end else begin : g_plain
      assign eq = (a == b);
    end
  endgenerate

endmodule

// File: rtl/counter_maximum.sv
// Up-counter with enable and run-time wrap limit: counts 0..max then wraps to 0.
// wrp is combinational (cnt == max); architecture selected by IMPLEMENTATION.
module counter_maximum #(
  parameter int WIDTH          = 4,
  parameter int IMPLEMENTATION = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] cnt,
  output logic             wrp
);

  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] cnt_nxt;

  counter_maximum_cmp #(
    .WIDTH         (WIDTH),
    .IMPLEMENTATION(IMPLEMENTATION)
  ) u_cmp (
    .a (cnt),
    .b (max),
    .eq(wrp)
  );

  generate
    if (IMPLEMENTATION == 1) begin : g_carry_chain
      logic [WIDTH:0] carry;

      // Explicit ripple incrementer; bit i toggles when all lower bits are set.
      always_comb begin
        carry    = '0;
        carry[0] = 1'b1;
        cnt_inc  = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
          cnt_inc[i]  = cnt[i] ^ carry[i];
          carry[i+1]  = cnt[i] & carry[i];
        end
      end
    end else begin : g_adder
      assign cnt_inc = cnt + WIDTH'(1);
    end
  endgenerate

  always_comb begin
    cnt_nxt = cnt;
    if (ena) begin
      cnt_nxt = wrp ? '0 : cnt_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_counter_maximum.sv
// Directed bench for counter_maximum: both architectures run side by side
// against a scoreboard fed by a cycle-level reference model.
module tb_counter_maximum;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena;
  logic [W-1:0] max;
  logic [W-1:0] cnt0, cnt1;
  logic         wrp0, wrp1;

  always #5 clk = ~clk;

  counter_maximum #(.WIDTH(W), .IMPLEMENTATION(0)) dut0 (
    .clk(clk), .rst(rst), .ena(ena), .max(max), .cnt(cnt0), .wrp(wrp0)
  );

  counter_maximum #(.WIDTH(W), .IMPLEMENTATION(1)) dut1 (
    .clk(clk), .rst(rst), .ena(ena), .max(max), .cnt(cnt1), .wrp(wrp1)
  );

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         wrp;
    logic         chk_wrp;
  } exp_t;

  exp_t         sb[$];
  int           compared   = 0;
  int           mismatched = 0;
  logic [W-1:0] mcnt;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, check #1 later (before the next posedge),
  // then advance the model using the inputs present at that posedge.
  task automatic cycle(input logic e, input logic [W-1:0] m, input logic r, input logic chk_wrp);
    exp_t x;
    @(negedge clk);
    rst = r;
    ena = e;
    max = m;
    if (r) mcnt = '0;
    x.cnt     = mcnt;
    x.wrp     = (mcnt == m);
    x.chk_wrp = chk_wrp;
    sb.push_back(x);
    #1;
    x = sb.pop_front();
    check("cnt_impl0", cnt0, x.cnt);
    check("cnt_impl1", cnt1, x.cnt);
    if (x.chk_wrp) begin
      check("wrp_impl0", W'(wrp0), W'(x.wrp));
      check("wrp_impl1", W'(wrp1), W'(x.wrp));
    end
    if (!r && e) mcnt = (mcnt == m) ? '0 : mcnt + W'(1);
  endtask

  initial begin
    rst  = 1'b1;
    ena  = 1'b1;
    max  = '0;
    mcnt = '0;

    // Reset held with ena=1, max=0, then max=0 keeps count pinned at 0.
    repeat (4)  cycle(1'b1, 4'd0, 1'b1, 1'b1);
    repeat (18) cycle(1'b1, 4'd0, 1'b0, 1'b1);

    // max=1 toggles 0,1,0,1
    repeat (8) cycle(1'b1, 4'd1, 1'b0, 1'b1);

    // Full range with wrap past all-ones
    repeat (2)  cycle(1'b1, 4'd0, 1'b1, 1'b1);
    repeat (18) cycle(1'b1, 4'd15, 1'b0, 1'b1);

    // Random enable
    repeat (30) cycle(1'($urandom_range(0, 1)), 4'd15, 1'b0, 1'b1);

    // Limit lowered below the current count at cnt=10
    repeat (2)  cycle(1'b1, 4'd15, 1'b1, 1'b1);
    repeat (10) cycle(1'b1, 4'd15, 1'b0, 1'b1);
    repeat (12) cycle(1'b1, 4'd3, 1'b0, 1'b1);

    // Limit raised while cnt equals the old limit
    while (mcnt != 4'd3) cycle(1'b1, 4'd3, 1'b0, 1'b1);
    repeat (4) cycle(1'b1, 4'd5, 1'b0, 1'b1);

    // Asynchronous reset at cnt=7, asserted between edges
    repeat (2) cycle(1'b1, 4'd15, 1'b1, 1'b1);
    repeat (7) cycle(1'b1, 4'd15, 1'b0, 1'b1);
    repeat (2) cycle(1'b1, 4'd15, 1'b1, 1'b1);
    repeat (5) cycle(1'b1, 4'd15, 1'b0, 1'b1);

    // Unknown limit while disabled must not disturb the count
    repeat (3) cycle(1'b0, 'x, 1'b0, 1'b0);
    repeat (3) cycle(1'b1, 4'd15, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
